m_imem_loader: RTL

Boot-time program loader that sits directly upstream of the processor core's instruction memory. It accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, and writes them to consecutive word addresses of the instruction memory's write port. It holds the processor core in reset until the image is fully written, then releases it.

---
 rtl/m_imem_loader_pkg.sv | 27 ++
 rtl/m_imem_loader_packer.sv | 34 +++
 rtl/m_imem_loader.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/m_imem_loader_pkg.sv
// Shared definitions for the boot-time instruction-memory loader.
// Holds the FSM state encodings, stream framing constants and the
// capacity helper used to bound the header word count.
package m_imem_loader_pkg;

  typedef enum logic [2:0] {
    S_HDR0 = 3'd0,
    S_HDR1 = 3'd1,
    S_WORD = 3'd2,
    S_CHK  = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int DEF_ADDR_W     = 12;

  // Memory capacity in words, 2^addr_w; 17 bits so a 16-bit header
  // count can be compared against it without overflow.
  function automatic logic [16:0] f_capacity(input int addr_w);
    return 17'(1) << addr_w;
  endfunction

  localparam logic [16:0] DEF_CAPACITY = f_capacity(DEF_ADDR_W);

endpackage

// File: rtl/m_imem_loader_packer.sv
// m_byte_packer: assembles four LSB-first bytes into a 32-bit word.
// Latency: combinational word-valid/word on the cycle the 4th byte is offered.
// Backpressure: none; consumes every byte presented on w_byte_vld.
// Ports: w_clk/w_rst (sync, active-high), w_flush clears position and
//   partial data, w_byte_vld/w_byte input byte, w_word_vld/w_word output.
module m_byte_packer (
  input  logic        w_clk,
  input  logic        w_rst,
  input  logic        w_flush,
  input  logic        w_byte_vld,
  input  logic [7:0]  w_byte,
  output logic        w_word_vld,
  output logic [31:0] w_word
);

  logic [1:0]  r_idx;
  // Only the first three bytes need storage; the fourth is taken straight
  // from the input lane when the word completes.
  logic [23:0] r_sr;

  assign w_word_vld = w_byte_vld && (r_idx == 2'd3);
  assign w_word     = {w_byte, r_sr};

  always_ff @(posedge w_clk) begin
    if (w_rst || w_flush) begin
      r_idx <= 2'd0;
      r_sr  <= 24'd0;
    end else if (w_byte_vld) begin
      r_idx <= r_idx + 2'd1;
      r_sr  <= {w_byte, r_sr[23:8]};
    end
  end

endmodule

// File: rtl/m_imem_loader.sv
// m_imem_loader: boot loader writing a framed byte stream into instruction
//   memory and holding the core in reset until the image is in place.
// Latency: write strobe one cycle after the 4th byte of a word transfers.
// Backpressure: ready only in header/payload/checksum states, never stalls
//   mid-payload; drops ready once done or in error.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (adds 4-byte sum check).
// Ports: w_clk, w_rst (sync active-high); w_rx_data/w_rx_valid/r_rx_ready
//   byte handshake; r_mem_we/r_mem_addr/r_mem_din memory write port;
//   r_proc_rst core reset; r_done/r_err sticky status; r_words word count.
module m_imem_loader
  import m_imem_loader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              w_clk,
  input  logic              w_rst,
  input  logic [7:0]        w_rx_data,
  input  logic              w_rx_valid,
  output logic              r_rx_ready,
  output logic              r_mem_we,
  output logic [ADDR_W-1:0] r_mem_addr,
  output logic [31:0]       r_mem_din,
  output logic              r_proc_rst,
  output logic              r_done,
  output logic              r_err,
  output logic [ADDR_W:0]   r_words
);

  localparam logic [16:0] CAPACITY = f_capacity(ADDR_W);

  state_t        r_state;
  logic [15:0]   r_n;

  logic          w_xfer;
  logic [15:0]   w_n;
  logic          w_flush;
  logic          w_pk_vld;
  logic          w_word_vld;
  logic [31:0]   w_word;
  logic [ADDR_W:0] w_words_nxt;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]   r_sum;
`endif

  assign w_xfer      = w_rx_valid && r_rx_ready;
  assign w_n         = {w_rx_data, r_n[7:0]};
  // Packer starts every payload from byte position 0.
  assign w_flush     = w_xfer && (r_state == S_HDR1);
  assign w_pk_vld    = w_xfer && ((r_state == S_WORD) || (r_state == S_CHK));
  assign w_words_nxt = r_words + 1'b1;

  m_byte_packer u_packer (
    .w_clk      (w_clk),
    .w_rst      (w_rst),
    .w_flush    (w_flush),
    .w_byte_vld (w_pk_vld),
    .w_byte     (w_rx_data),
    .w_word_vld (w_word_vld),
    .w_word     (w_word)
  );

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_state    <= S_HDR0;
      r_n        <= 16'd0;
      r_rx_ready <= 1'b0;
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_din  <= 32'd0;
      r_proc_rst <= 1'b1;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_words    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_sum      <= 32'd0;
`endif
    end else begin
      r_mem_we <= 1'b0;
      case (r_state)
        S_HDR0: begin
          r_rx_ready <= 1'b1;
          if (w_xfer) begin
            r_n[7:0] <= w_rx_data;
            r_state  <= S_HDR1;
          end
        end

        S_HDR1: begin
          if (w_xfer) begin
            r_n <= w_n;
            if (w_n == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              r_state    <= S_CHK;
`else
              // Nothing was written, so the core may start immediately.
              r_state    <= S_DONE;
              r_rx_ready <= 1'b0;
              r_done     <= 1'b1;
              r_proc_rst <= 1'b0;
`endif
            end else if ({1'b0, w_n} > CAPACITY) begin
              r_state    <= S_ERR;
              r_rx_ready <= 1'b0;
              r_err      <= 1'b1;
            end else begin
              r_state <= S_WORD;
            end
          end
        end

        S_WORD: begin
          if (w_word_vld) begin
            r_mem_we   <= 1'b1;
            r_mem_addr <= r_words[ADDR_W-1:0];
            r_mem_din  <= w_word;
            r_words    <= w_words_nxt;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_sum      <= r_sum + w_word;
`endif
            if (16'(w_words_nxt) == r_n) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              r_state    <= S_CHK;
`else
              // Done is raised from S_DONE one cycle later, so it never
              // overlaps the final write strobe.
              r_state    <= S_DONE;
              r_rx_ready <= 1'b0;
`endif
            end
          end
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHK: begin
          // The last payload write is at least four cycles old here, so
          // done can be raised directly on a match.
          if (w_word_vld) begin
            r_rx_ready <= 1'b0;
            if (w_word == r_sum) begin
              r_state    <= S_DONE;
              r_done     <= 1'b1;
              r_proc_rst <= 1'b0;
            end else begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end
          end
        end
`endif

        S_DONE: begin
          r_rx_ready <= 1'b0;
          r_done     <= 1'b1;
          r_proc_rst <= 1'b0;
        end

        S_ERR: begin
          r_rx_ready <= 1'b0;
          r_err      <= 1'b1;
          r_proc_rst <= 1'b1;
        end

        default: begin
          r_state    <= S_ERR;
          r_rx_ready <= 1'b0;
          r_err      <= 1'b1;
        end
      endcase
    end
  end

endmodule
